// File: rtl/bster_pkg.sv
// rtl/bster_pkg.sv - shared types and constants for the bster command arbiter
package bster_pkg;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ARB_IDLE = 1'b0;
    localparam arb_state_t ARB_XFER = 1'b1;

    localparam int BSTER_CMD_WIDTH = 128;
    localparam int BSTER_STS_WIDTH = 8;

    // A single requester still needs a one-bit ID field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bster_id_fifo.sv
// rtl/bster_id_fifo.sv - in-order FIFO of granted requester IDs
module bster_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/bster_cmd_arbiter.sv
// rtl/bster_cmd_arbiter.sv - round-robin command arbiter with in-order cpl/sts return routing
module bster_cmd_arbiter
    import bster_pkg::*;
#(
    parameter int NB_REQ          = 4,
    parameter int CMD_WIDTH       = BSTER_CMD_WIDTH,
    parameter int STS_WIDTH       = BSTER_STS_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [NB_REQ-1:0]                  req_tvalid,
    output logic [NB_REQ-1:0]                  req_tready,
    input  logic [NB_REQ*CMD_WIDTH-1:0]        req_tdata,
    output logic                               cmd_tvalid,
    input  logic                               cmd_tready,
    output logic [CMD_WIDTH-1:0]               cmd_tdata,
    input  logic                               cpl_tvalid,
    output logic                               cpl_tready,
    input  logic [CMD_WIDTH-1:0]               cpl_tdata,
    input  logic                               sts_tvalid,
    output logic                               sts_tready,
    input  logic [STS_WIDTH-1:0]               sts_tdata,
    output logic [NB_REQ-1:0]                  req_cpl_tvalid,
    input  logic [NB_REQ-1:0]                  req_cpl_tready,
    output logic [CMD_WIDTH-1:0]               req_cpl_tdata,
    output logic [NB_REQ-1:0]                  req_sts_tvalid,
    input  logic [NB_REQ-1:0]                  req_sts_tready,
    output logic [STS_WIDTH-1:0]               req_sts_tdata,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_orphan
);

    localparam int IDW = id_width(NB_REQ);
    localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           cpl_done_q, cpl_done_d;
    logic           sts_done_q, sts_done_d;
    logic           err_q, err_d;

    logic [IDW-1:0] head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [OW-1:0]  fifo_count;
    logic           cmd_hs;
    logic           pop;
    logic           cpl_now;
    logic           sts_now;
    logic [IDW-1:0] rr_pick;
    logic           rr_found;
    logic [CMD_WIDTH-1:0] req_cmd [NB_REQ];

    always_comb begin
        for (int i = 0; i < NB_REQ; i++) begin
            req_cmd[i] = req_tdata[i*CMD_WIDTH +: CMD_WIDTH];
        end
    end

    // First valid requester at or after the pointer, scanning cyclically.
    always_comb begin
        int idx;
        idx      = 0;
        rr_pick  = ptr_q;
        rr_found = 1'b0;
        for (int k = 0; k < NB_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NB_REQ) begin
                idx = idx - NB_REQ;
            end
            if (!rr_found && req_tvalid[idx]) begin
                rr_found = 1'b1;
                rr_pick  = IDW'(idx);
            end
        end
    end

    assign cmd_tvalid = (state_q == ARB_XFER) & req_tvalid[grant_q];
    assign cmd_tdata  = req_cmd[grant_q];
    assign cmd_hs     = cmd_tvalid & cmd_tready;

    always_comb begin
        req_tready = '0;
        if (state_q == ARB_XFER) begin
            req_tready[grant_q] = cmd_tready;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (state_q == ARB_IDLE) begin
            if (rr_found && !fifo_full) begin
                grant_d = rr_pick;
                state_d = ARB_XFER;
            end
        end else if (cmd_hs) begin
            ptr_d   = (grant_q == IDW'(NB_REQ-1)) ? '0 : grant_q + 1'b1;
            state_d = ARB_IDLE;
        end
    end

    // With nothing in flight, beats are swallowed so the engine never stalls.
    always_comb begin
        req_cpl_tvalid = '0;
        req_sts_tvalid = '0;
        cpl_tready     = 1'b0;
        sts_tready     = 1'b0;
        if (fifo_empty) begin
            cpl_tready = cpl_tvalid;
            sts_tready = sts_tvalid;
        end else begin
            for (int i = 0; i < NB_REQ; i++) begin
                if (head == IDW'(i)) begin
                    req_cpl_tvalid[i] = cpl_tvalid & ~cpl_done_q;
                    req_sts_tvalid[i] = sts_tvalid & ~sts_done_q;
                    cpl_tready        = req_cpl_tready[i] & ~cpl_done_q;
                    sts_tready        = req_sts_tready[i] & ~sts_done_q;
                end
            end
        end
    end

    assign cpl_now    = cpl_done_q | (~fifo_empty & cpl_tvalid & cpl_tready);
    assign sts_now    = sts_done_q | (~fifo_empty & sts_tvalid & sts_tready);
    assign pop        = cpl_now & sts_now;
    assign cpl_done_d = cpl_now & ~pop;
    assign sts_done_d = sts_now & ~pop;
    assign err_d      = err_q | (fifo_empty & (cpl_tvalid | sts_tvalid));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            cpl_done_q <= 1'b0;
            sts_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cpl_done_q <= cpl_done_d;
            sts_done_q <= sts_done_d;
            err_q      <= err_d;
        end
    end

    bster_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk_i       (aclk),
        .rst_ni      (aresetn),
        .push_i      (cmd_hs),
        .push_data_i (grant_q),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign req_cpl_tdata = cpl_tdata;
    assign req_sts_tdata = sts_tdata;
    assign outstanding   = fifo_count;
    assign err_orphan    = err_q;

endmodule

// File: tb/tb_bster_cmd_arbiter.sv
// tb/tb_bster_cmd_arbiter.sv - self-checking bench for bster_cmd_arbiter
module tb_bster_cmd_arbiter;

    localparam int NB   = 4;
    localparam int CW   = 128;
    localparam int SW   = 8;
    localparam int MAXO = 4;
    localparam int OW   = 3;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [NB-1:0]    req_tvalid;
    logic [NB-1:0]    req_tready;
    logic [NB*CW-1:0] req_tdata;
    logic             cmd_tvalid;
    logic             cmd_tready;
    logic [CW-1:0]    cmd_tdata;
    logic             cpl_tvalid;
    logic             cpl_tready;
    logic [CW-1:0]    cpl_tdata;
    logic             sts_tvalid;
    logic             sts_tready;
    logic [SW-1:0]    sts_tdata;
    logic [NB-1:0]    req_cpl_tvalid;
    logic [NB-1:0]    req_cpl_tready;
    logic [CW-1:0]    req_cpl_tdata;
    logic [NB-1:0]    req_sts_tvalid;
    logic [NB-1:0]    req_sts_tready;
    logic [SW-1:0]    req_sts_tdata;
    logic [OW-1:0]    outstanding;
    logic             err_orphan;

    always #5 aclk = ~aclk;

    bster_cmd_arbiter #(
        .NB_REQ          (NB),
        .CMD_WIDTH       (CW),
        .STS_WIDTH       (SW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .req_tvalid     (req_tvalid),
        .req_tready     (req_tready),
        .req_tdata      (req_tdata),
        .cmd_tvalid     (cmd_tvalid),
        .cmd_tready     (cmd_tready),
        .cmd_tdata      (cmd_tdata),
        .cpl_tvalid     (cpl_tvalid),
        .cpl_tready     (cpl_tready),
        .cpl_tdata      (cpl_tdata),
        .sts_tvalid     (sts_tvalid),
        .sts_tready     (sts_tready),
        .sts_tdata      (sts_tdata),
        .req_cpl_tvalid (req_cpl_tvalid),
        .req_cpl_tready (req_cpl_tready),
        .req_cpl_tdata  (req_cpl_tdata),
        .req_sts_tvalid (req_sts_tvalid),
        .req_sts_tready (req_sts_tready),
        .req_sts_tdata  (req_sts_tdata),
        .outstanding    (outstanding),
        .err_orphan     (err_orphan)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: a locked grant, a pointer, and a queue of issued IDs.
    bit m_locked;
    int m_grant;
    int m_ptr;
    int m_q[$];
    bit m_cd;
    bit m_sd;
    bit m_err;
    int granted[$];

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_locked = 1'b0;
            m_grant  = 0;
            m_ptr    = 0;
            m_q.delete();
            m_cd     = 1'b0;
            m_sd     = 1'b0;
            m_err    = 1'b0;
        end else begin
            int size0;
            int h;
            bit cnow;
            bit snow;
            size0 = m_q.size();
            if (size0 == 0) begin
                if (cpl_tvalid || sts_tvalid) m_err = 1'b1;
            end else begin
                h    = m_q[0];
                cnow = m_cd || (cpl_tvalid && req_cpl_tready[h]);
                snow = m_sd || (sts_tvalid && req_sts_tready[h]);
                if (cnow && snow) begin
                    void'(m_q.pop_front());
                    m_cd = 1'b0;
                    m_sd = 1'b0;
                end else begin
                    m_cd = cnow;
                    m_sd = snow;
                end
            end
            if (m_locked) begin
                if (req_tvalid[m_grant] && cmd_tready) begin
                    m_q.push_back(m_grant);
                    granted.push_back(m_grant);
                    m_ptr    = (m_grant + 1) % NB;
                    m_locked = 1'b0;
                end
            end else if (req_tvalid != '0 && size0 < MAXO) begin
                for (int k = 0; k < NB; k++) begin
                    if (req_tvalid[(m_ptr + k) % NB]) begin
                        m_grant = (m_ptr + k) % NB;
                        break;
                    end
                end
                m_locked = 1'b1;
            end
        end
    end

    always @(negedge aclk) begin
        logic [NB-1:0] e_rt;
        logic [NB-1:0] e_cv;
        logic [NB-1:0] e_sv;
        logic          e_cmdv;
        logic          e_ct;
        logic          e_st;
        e_cmdv = m_locked && req_tvalid[m_grant];
        e_rt   = '0;
        if (m_locked) e_rt[m_grant] = cmd_tready;
        e_cv = '0;
        e_sv = '0;
        if (m_q.size() == 0) begin
            e_ct = cpl_tvalid;
            e_st = sts_tvalid;
        end else begin
            e_cv[m_q[0]] = cpl_tvalid && !m_cd;
            e_sv[m_q[0]] = sts_tvalid && !m_sd;
            e_ct = req_cpl_tready[m_q[0]] && !m_cd;
            e_st = req_sts_tready[m_q[0]] && !m_sd;
        end
        chk("cmd_tvalid", CW'(cmd_tvalid), CW'(e_cmdv));
        if (e_cmdv) chk("cmd_tdata", cmd_tdata, req_tdata[m_grant*CW +: CW]);
        chk("req_tready", CW'(req_tready), CW'(e_rt));
        chk("req_cpl_tvalid", CW'(req_cpl_tvalid), CW'(e_cv));
        chk("req_sts_tvalid", CW'(req_sts_tvalid), CW'(e_sv));
        chk("cpl_tready", CW'(cpl_tready), CW'(e_ct));
        chk("sts_tready", CW'(sts_tready), CW'(e_st));
        chk("req_cpl_tdata", req_cpl_tdata, cpl_tdata);
        chk("req_sts_tdata", CW'(req_sts_tdata), CW'(sts_tdata));
        chk("outstanding", CW'(outstanding), CW'(m_q.size()));
        chk("err_orphan", CW'(err_orphan), CW'(m_err));
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        req_tvalid     = '0;
        cmd_tready     = 1'b1;
        cpl_tvalid     = 1'b0;
        sts_tvalid     = 1'b0;
        cpl_tdata      = '0;
        sts_tdata      = '0;
        req_cpl_tready = '0;
        req_sts_tready = '0;
    endtask

    task automatic set_data();
        for (int i = 0; i < NB; i++) begin
            req_tdata[i*CW +: CW] = {$urandom, $urandom, $urandom, 24'h0, 8'(i)};
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        idle_inputs();
        repeat (2) step();
        granted.delete();
        aresetn = 1'b1;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int c = 0;
        while (granted.size() < n && c < budget) begin
            step();
            c++;
        end
        chk("grant_wait", CW'(granted.size() >= n), CW'(1));
    endtask

    int exp_b[5] = '{0, 1, 2, 3, 0};
    logic [CW-1:0] held;

    initial begin
        idle_inputs();
        set_data();
        repeat (2) @(negedge aclk);
        chk("rst_cmd_tvalid", CW'(cmd_tvalid), 0);
        chk("rst_req_tready", CW'(req_tready), 0);
        chk("rst_outstanding", CW'(outstanding), 0);
        chk("rst_err", CW'(err_orphan), 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;

        // Saturate: all requesters valid, engine never completes.
        req_tvalid = '1;
        repeat (12) step();
        chk("b_ngrants", CW'(granted.size()), 4);
        chk("b_outstanding", CW'(outstanding), 4);
        @(negedge aclk);
        chk("b_tready_full", CW'(req_tready), 0);
        step();
        cpl_tvalid = 1'b1; sts_tvalid = 1'b1;
        req_cpl_tready = '1; req_sts_tready = '1;
        cpl_tdata = {$urandom, $urandom, $urandom, $urandom};
        step();
        cpl_tvalid = 1'b0; sts_tvalid = 1'b0;
        repeat (6) step();
        chk("b_ngrants5", CW'(granted.size()), 5);
        chk("b_outstanding_refill", CW'(outstanding), 4);
        for (int i = 0; i < 5; i++) begin
            if (i < granted.size()) chk("b_order", CW'(granted[i]), CW'(exp_b[i]));
        end

        // Single command from requester 2, status then completion 3 cycles later.
        do_reset();
        req_tvalid = 4'b0100;
        wait_grants(1, 10);
        req_tvalid = '0;
        if (granted.size() > 0) chk("c_grant", CW'(granted[0]), 2);
        sts_tdata = 8'h5A; sts_tvalid = 1'b1; req_sts_tready = '1; req_cpl_tready = '1;
        @(negedge aclk);
        chk("c_sts_route", CW'(req_sts_tvalid), 4'b0100);
        chk("c_cpl_none", CW'(req_cpl_tvalid), 0);
        step();
        sts_tvalid = 1'b0;
        repeat (2) step();
        cpl_tvalid = 1'b1;
        @(negedge aclk);
        chk("c_cpl_route", CW'(req_cpl_tvalid), 4'b0100);
        chk("c_sts_none", CW'(req_sts_tvalid), 0);
        chk("c_outst_before", CW'(outstanding), 1);
        step();
        cpl_tvalid = 1'b0;
        @(negedge aclk);
        chk("c_outst_after", CW'(outstanding), 0);
        step();

        // Head requester 1 back-pressures its completion for 5 cycles.
        req_tvalid = 4'b0010;
        wait_grants(2, 10);
        req_tvalid = '0;
        cpl_tdata = {$urandom, $urandom, $urandom, $urandom};
        held = cpl_tdata;
        cpl_tvalid = 1'b1;
        req_cpl_tready = 4'b1101;
        repeat (5) begin
            @(negedge aclk);
            chk("d_cpl_tready", CW'(cpl_tready), 0);
            chk("d_route", CW'(req_cpl_tvalid), 4'b0010);
            chk("d_tdata", req_cpl_tdata, held);
            step();
        end
        req_cpl_tready = '1; sts_tvalid = 1'b1; req_sts_tready = '1;
        step();
        cpl_tvalid = 1'b0; sts_tvalid = 1'b0;
        @(negedge aclk);
        chk("d_outst", CW'(outstanding), 0);
        step();

        // Orphan completion with nothing in flight.
        req_cpl_tready = '0;
        cpl_tvalid = 1'b1;
        @(negedge aclk);
        chk("e_cpl_tready", CW'(cpl_tready), 1);
        chk("e_err_before", CW'(err_orphan), 0);
        step();
        cpl_tvalid = 1'b0;
        repeat (3) step();
        chk("e_err_sticky", CW'(err_orphan), 1);

        // Reset while a third command is stalled in transfer with 2 in flight.
        do_reset();
        chk("f_err_cleared", CW'(err_orphan), 0);
        req_tvalid = 4'b0011;
        wait_grants(2, 10);
        req_tvalid = 4'b0100;
        cmd_tready = 1'b0;
        repeat (3) step();
        @(negedge aclk);
        chk("f_cmd_stall", CW'(cmd_tvalid), 1);
        chk("f_outst2", CW'(outstanding), 2);
        #2 aresetn = 1'b0;
        req_tvalid = 4'b1010;
        cmd_tready = 1'b1;
        #1;
        chk("f_rst_cmdv", CW'(cmd_tvalid), 0);
        chk("f_rst_tready", CW'(req_tready), 0);
        chk("f_rst_outst", CW'(outstanding), 0);
        step();
        granted.delete();
        aresetn = 1'b1;
        wait_grants(1, 10);
        if (granted.size() > 0) chk("f_first_grant", CW'(granted[0]), 1);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) set_data();
            req_tvalid     = NB'($urandom);
            cmd_tready     = ($urandom_range(0, 3) != 0);
            cpl_tvalid     = ($urandom_range(0, 2) == 0);
            sts_tvalid     = ($urandom_range(0, 2) == 0);
            cpl_tdata      = {$urandom, $urandom, $urandom, $urandom};
            sts_tdata      = SW'($urandom);
            req_cpl_tready = NB'($urandom | $urandom);
            req_sts_tready = NB'($urandom | $urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
